// File: rtl/px_capture_pkg.sv
// Shared definitions for the pixel capture controller.
// Holds the Avalon-MM register map, the bit positions inside the status,
// ctrl, clear and data words, and the x/y packing used for FIFO entries.
package px_capture_pkg;

    // Avalon-MM word addresses
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_CLEAR  = 2'd3
    } reg_addr_e;

    // Data word: entry in the low bits, valid flag on top
    localparam int DATA_VALID_BIT  = 31;

    // Entry packing: x in the low half, y in the high half
    localparam int ENTRY_PX_LSB    = 0;

    // Status word fields
    localparam int STAT_CNT_LSB    = 0;
    localparam int STAT_OVF_BIT    = 8;
    localparam int STAT_EMPTY_BIT  = 9;
    localparam int STAT_FULL_BIT   = 10;

    // Ctrl word fields
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Clear word fields
    localparam int CLR_FIFO_BIT    = 0;
    localparam int CLR_OVF_BIT     = 1;

endpackage

// File: rtl/px_capture_if.sv
// Avalon-MM slave bus of the pixel capture controller.
//   address   : word address (2 bits)
//   read      : single-cycle read strobe
//   write     : single-cycle write strobe
//   writedata : 32-bit write data
//   readdata  : 32-bit read data, valid one cycle after read
interface px_capture_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output read, output write, output writedata,
                    input  readdata);
    modport slave  (input  address, input  read, input  write, input  writedata,
                    output readdata);
endinterface

// File: rtl/px_capture_fifo.sv
// Synchronous FIFO holding captured pixel entries.
//   clk, reset_n : clock, async active-low reset (pointers and count only)
//   clear_i      : empties the FIFO; wins over a same-cycle push/pop
//   push_i       : write push_data_i; accepted if not full or a pop frees a slot
//   pop_i        : drop the head entry; ignored when empty
//   pop_data_o   : current head entry (show-ahead)
//   full_o, empty_o, count_o : occupancy, count in 0..DEPTH
module px_capture_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff_s;
    logic             push_eff_s;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the same cycle pops a slot free
    assign pop_eff_s  = pop_i & ~empty_o;
    assign push_eff_s = push_i & (~full_o | pop_eff_s);

    // Next-state pointers and count; power-of-two DEPTH makes pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_eff_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_eff_s) - CNT_W'(pop_eff_s);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, deliberately unreset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_eff_s && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/px_capture_ctrl.sv
// Pixel capture controller: queues strobed (x,y) samples in a FIFO and
// exposes them to software through a 4-word Avalon-MM register map.
//   clk, reset_n          : clock, async active-low reset
//   avs                   : Avalon-MM slave (address/read/write/writedata/readdata)
//   irq                   : registered level interrupt
//   in_px, in_py          : sample coordinates
//   in_strobe             : one-cycle sample request
module px_capture_ctrl
    import px_capture_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    px_capture_if.slave        avs,
    output logic               irq,
    input  logic [COORD_W-1:0] in_px,
    input  logic [COORD_W-1:0] in_py,
    input  logic               in_strobe
);

    localparam int ENTRY_W = 2 * COORD_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               enable_q,   enable_d;
    logic               irq_en_q,   irq_en_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               irq_q,      irq_d;

    logic [ENTRY_W-1:0] fifo_head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_pop_s;
    logic               fifo_clear_s;
    logic               push_req_s;
    logic               overflow_set_s;

    assign push_req_s     = in_strobe & enable_q;
    assign fifo_pop_s     = avs.read & (avs.address == REG_DATA) & ~fifo_empty_s;
    assign fifo_clear_s   = avs.write & (avs.address == REG_CLEAR) & avs.writedata[CLR_FIFO_BIT];
    // A sample is lost only when no slot frees up and no clear discards it anyway
    assign overflow_set_s = push_req_s & fifo_full_s & ~fifo_pop_s & ~fifo_clear_s;

    px_capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (fifo_clear_s),
        .push_i      (push_req_s),
        .push_data_i ({in_py, in_px}),
        .pop_i       (fifo_pop_s),
        .pop_data_o  (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    // Ctrl and sticky overflow updates; an explicit clear beats a same-cycle overflow
    always_comb begin
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        overflow_d = overflow_q;
        if (avs.write && (avs.address == REG_CTRL)) begin
            enable_d = avs.writedata[CTRL_EN_BIT];
            irq_en_d = avs.writedata[CTRL_IRQ_EN_BIT];
        end else begin
            enable_d = enable_q;
            irq_en_d = irq_en_q;
        end
        if (avs.write && (avs.address == REG_CLEAR) && avs.writedata[CLR_OVF_BIT]) begin
            overflow_d = 1'b0;
        end else if (overflow_set_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Read data mux, captured only on a read so readdata holds otherwise
    always_comb begin
        readdata_d = readdata_q;
        if (avs.read) begin
            readdata_d = 32'd0;
            case (reg_addr_e'(avs.address))
                REG_DATA: begin
                    if (!fifo_empty_s) begin
                        readdata_d[ENTRY_PX_LSB +: ENTRY_W] = fifo_head_s;
                        readdata_d[DATA_VALID_BIT]          = 1'b1;
                    end else begin
                        readdata_d = 32'd0;
                    end
                end
                REG_STATUS: begin
                    readdata_d[STAT_CNT_LSB +: CNT_W] = fifo_count_s;
                    readdata_d[STAT_OVF_BIT]          = overflow_q;
                    readdata_d[STAT_EMPTY_BIT]        = fifo_empty_s;
                    readdata_d[STAT_FULL_BIT]         = fifo_full_s;
                end
                REG_CTRL: begin
                    readdata_d[CTRL_EN_BIT]     = enable_q;
                    readdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
                end
                REG_CLEAR: readdata_d = 32'd0;
                default:   readdata_d = 32'd0;
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    // Interrupt follows registered state, so it lags a state change by one cycle
    always_comb begin
        irq_d = irq_en_q & (~fifo_empty_s | overflow_q);
    end

    // Control, status and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_px_capture_ctrl.sv
// Self-checking bench for px_capture_ctrl: directed scenarios plus random
// traffic, all compared against a queue-based model of the register map.
module tb_px_capture_ctrl;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_n;
    logic       irq;
    logic [9:0] in_px;
    logic [9:0] in_py;
    logic       in_strobe;

    px_capture_if avs_if ();

    px_capture_ctrl #(.COORD_W(10), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .avs       (avs_if),
        .irq       (irq),
        .in_px     (in_px),
        .in_py     (in_py),
        .in_strobe (in_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model state
    logic [19:0] m_q[$];
    bit          m_ovf;
    bit          m_en;
    bit          m_ien;
    logic [31:0] m_rd;
    bit          m_irq;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'd0;
        s[4:0] = 5'(m_q.size());
        s[8]   = m_ovf;
        s[9]   = (m_q.size() == 0);
        s[10]  = (m_q.size() == DEPTH);
        return s;
    endfunction

    // One bus/sample cycle: drive, advance the model, check outputs after the edge
    task automatic cycle(input logic [1:0] a, input logic r, input logic w,
                         input logic [31:0] wd, input logic s,
                         input logic [9:0] x, input logic [9:0] y);
        bit pop;
        bit push;
        @(negedge clk);
        avs_if.address   = a;
        avs_if.read      = r;
        avs_if.write     = w;
        avs_if.writedata = wd;
        in_strobe        = s;
        in_px            = x;
        in_py            = y;

        m_irq = m_ien && (m_q.size() != 0 || m_ovf);
        if (r) begin
            case (a)
                2'd0: m_rd = (m_q.size() != 0) ? {1'b1, 11'd0, m_q[0]} : 32'd0;
                2'd1: m_rd = m_status();
                2'd2: m_rd = {30'd0, m_ien, m_en};
                default: m_rd = 32'd0;
            endcase
        end
        pop  = r && (a == 2'd0) && (m_q.size() != 0);
        push = s && m_en;
        if (w && a == 2'd3 && wd[0]) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back({y, x});
                else m_ovf = 1'b1;
            end
        end
        if (w && a == 2'd3 && wd[1]) m_ovf = 1'b0;
        if (w && a == 2'd2) begin
            m_en  = wd[0];
            m_ien = wd[1];
        end

        @(posedge clk);
        #1;
        chk_eq("readdata", avs_if.readdata, m_rd);
        chk_eq("irq", {31'd0, irq}, {31'd0, m_irq});
        avs_if.read  = 1'b0;
        avs_if.write = 1'b0;
        in_strobe    = 1'b0;
    endtask

    task automatic idle();
        cycle(2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 10'd0, 10'd0);
    endtask
    task automatic rd(input logic [1:0] a);
        cycle(a, 1'b1, 1'b0, 32'd0, 1'b0, 10'd0, 10'd0);
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cycle(a, 1'b0, 1'b1, d, 1'b0, 10'd0, 10'd0);
    endtask
    task automatic strobe(input logic [9:0] x, input logic [9:0] y);
        cycle(2'd0, 1'b0, 1'b0, 32'd0, 1'b1, x, y);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_ovf = 1'b0; m_en = 1'b0; m_ien = 1'b0; m_rd = 32'd0; m_irq = 1'b0;
        reset_n = 1'b0;
        avs_if.address = 2'd0; avs_if.read = 1'b0; avs_if.write = 1'b0;
        avs_if.writedata = 32'd0;
        in_strobe = 1'b0; in_px = 10'd0; in_py = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_readdata", avs_if.readdata, 32'd0);
        chk_eq("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single sample: py lands in [19:10], px in [9:0], valid in [31]
        rd(2'd1);
        chk_eq("status_after_reset", avs_if.readdata, 32'h0000_0200);
        wr(2'd2, 32'd1);
        strobe(10'h12A, 10'h3FF);
        rd(2'd0);
        chk_eq("single_sample", avs_if.readdata, 32'h800F_FD2A);
        rd(2'd1);
        chk_eq("single_empty", avs_if.readdata, 32'h0000_0200);
        rd(2'd0);
        chk_eq("empty_pop", avs_if.readdata, 32'd0);

        // Overflow: five samples into four slots
        for (int i = 0; i < 5; i++) strobe(10'(i + 1), 10'(i + 100));
        rd(2'd1);
        chk_eq("overflow_status", avs_if.readdata, 32'h0000_0504);
        for (int i = 0; i < 4; i++) begin
            rd(2'd0);
            chk_eq("overflow_order", avs_if.readdata, {1'b1, 11'd0, 10'(i + 100), 10'(i + 1)});
        end
        wr(2'd3, 32'd2);
        rd(2'd1);
        chk_eq("ovf_cleared", avs_if.readdata, 32'h0000_0200);

        // Full FIFO with same-cycle push and pop
        for (int i = 0; i < 4; i++) strobe(10'(i + 7), 10'(i + 9));
        cycle(2'd0, 1'b1, 1'b0, 32'd0, 1'b1, 10'h055, 10'h0AA);
        chk_eq("full_pushpop_head", avs_if.readdata, {1'b1, 11'd0, 10'd9, 10'd7});
        rd(2'd1);
        chk_eq("full_pushpop_status", avs_if.readdata, 32'h0000_0404);
        wr(2'd3, 32'd1);

        // Interrupt from occupancy and from overflow
        wr(2'd2, 32'd3);
        strobe(10'd1, 10'd2);
        idle();
        chk_eq("irq_set", {31'd0, irq}, 32'd1);
        rd(2'd0);
        idle();
        chk_eq("irq_pop", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 5; i++) strobe(10'(i), 10'(i));
        for (int i = 0; i < 4; i++) rd(2'd0);
        idle();
        chk_eq("irq_ovf", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'd2);
        idle();
        chk_eq("irq_ovf_clr", {31'd0, irq}, 32'd0);

        // Disabled capture, and clear racing a push
        wr(2'd2, 32'd0);
        strobe(10'd5, 10'd6);
        rd(2'd1);
        chk_eq("disabled", avs_if.readdata, 32'h0000_0200);
        wr(2'd2, 32'd1);
        cycle(2'd3, 1'b0, 1'b1, 32'd1, 1'b1, 10'd8, 10'd8);
        rd(2'd1);
        chk_eq("clear_beats_push", avs_if.readdata, 32'h0000_0200);
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd2);
        chk_eq("ro_writes_ignored", avs_if.readdata, 32'd1);

        // Random traffic
        wr(2'd2, 32'd3);
        for (int i = 0; i < 600; i++) begin
            int          op;
            logic [31:0] d;
            op = int'($urandom_range(0, 9));
            d  = $urandom;
            if (op < 4) begin
                cycle(2'($urandom_range(0, 3)), 1'b1, 1'b0, 32'd0,
                      1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom));
            end else if (op == 4) begin
                d[0] = ($urandom_range(0, 3) != 0);
                cycle(2'd2, 1'b0, 1'b1, d, 1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom));
            end else if (op == 5) begin
                cycle(2'($urandom_range(0, 3)), 1'b0, 1'b1, d,
                      1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom));
            end else begin
                cycle(2'd0, 1'b0, 1'b0, 32'd0, 1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom));
            end
        end

        // Reset in the middle of operation
        wr(2'd3, 32'd3);
        wr(2'd2, 32'd3);
        for (int i = 0; i < 3; i++) strobe(10'(i), 10'(i));
        rd(2'd1);
        chk_eq("pre_reset_status", avs_if.readdata, 32'h0000_0003);
        idle();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_eq("async_rst_readdata", avs_if.readdata, 32'd0);
        chk_eq("async_rst_irq", {31'd0, irq}, 32'd0);
        m_q.delete();
        m_ovf = 1'b0; m_en = 1'b0; m_ien = 1'b0; m_rd = 32'd0; m_irq = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd1);
        chk_eq("post_reset_status", avs_if.readdata, 32'h0000_0200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
